apb_top: RTL and testbench
==========================

# apb_top

Self-contained AMBA APB5-style subsystem: an APB requester (master) converts single-cycle `transfer` requests from a local command interface into APB SETUP/ACCESS transactions, and an internal zero-wait-state APB completer (slave) backs them with a byte-strobed register memory. The internal APB bus is exposed on output ports for observation and protocol checking. It is a bring-up and verification vehicle for APB protocol features: byte strobes, PPROT/PNSE protection attributes and PSLVERR.

## Interface
- `DEPTH`, 16: number of 32-bit words in the completer memory. The valid byte address range is 0 to DEPTH*4-1.
- `PCLK` in 1: single clock; all logic is rising-edge.
- `PRESETn` in 1: reset, asynchronous and active-low.
- `transfer` in 1: request strobe; sampled high in IDLE starts one transaction.
- `write_en` in 1: 1 = write, 0 = read.
- `waddr` in 32: byte address, for both reads and writes.
- `wdata` in 32: write data.
- `strb` in 4: write byte strobes; bit n enables byte lane [8n+7:8n].
- `prot` in 3: protection attributes, driven to PPROT.
- `pnse` in 1: non-secure extension attribute, driven to PNSE.
- `error` out 1: registered PSLVERR of the last completed transfer.
- `rdata` out 32: registered read data of the last completed read.
- `PSELx` out 1: APB select.
- `PENABLE` out 1: APB enable.
- `PADDR` out 32: APB address.
- `PWRITE` out 1: APB direction.
- `PWDATA` out 32: APB write data.
- `PSTRB` out 4: APB strobes.
- `PRDATA` out 32: completer read data.
- `PREADY` out 1: completer ready.
- `PSLVERR` out 1: completer error.
- `PPROT` out 3: APB protection attributes.
- `PNSE` out 1: APB RME extension bit.

## Operation
- **Requester FSM** has three states:
  - IDLE: PSELx=0, PENABLE=0.
  - SETUP: PSELx=1, PENABLE=0.
  - ACCESS: PSELx=1, PENABLE=1.
- **Transitions:**
  - IDLE goes to SETUP when `transfer`=1 at a rising edge.
  - SETUP always goes to ACCESS.
  - ACCESS with PREADY=0 stays in ACCESS.
  - ACCESS with PREADY=1 goes to SETUP if `transfer`=1, else IDLE.
- **Request capture:** on the edge entering SETUP, capture `waddr`, `write_en`, `wdata`, `strb`, `prot`, `pnse` into PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE. These stay stable through ACCESS.
  - For reads, PSTRB = 4'b0000.
  - `transfer` outside IDLE or an ACCESS completion edge is ignored.
- **Completer:**
  - PREADY is held at 1 (zero wait states).
  - PRDATA is combinational: mem[PADDR[31:2]] when PSELx & !PWRITE and the address is valid, else 0.
  - PSLVERR = PSELx & PENABLE & (PADDR >= DEPTH*4 or PADDR[1:0] != 0).
  - **Write commit:** at the ACCESS & PREADY edge with PWRITE=1 and no error, each byte lane whose PSTRB bit is set is written. Unstrobed lanes keep their old value.
  - **Errored access:** no memory update; PRDATA=0.
  - PPROT and PNSE are pass-through attributes only; they never block an access.
- **Completion:** at the ACCESS & PREADY edge, `error` is loaded with PSLVERR. On reads, `rdata` is loaded with PRDATA (0 on error). `rdata` is unchanged by writes.
- **Reset:** all state clears to 0: FSM to IDLE, every output to 0, all memory words to 0. PREADY is constant 1.

## Timing
- If `transfer` is sampled high at edge k, SETUP spans cycles k to k+1 and ACCESS spans k+1 to k+2.
- The write commits, and `rdata`/`error` update, at edge k+2. Results are visible after edge k+2, two edges of latency.
- Back-to-back transfers: if `transfer` is high at the completion edge, the next SETUP follows with no IDLE cycle.
- Reset asserted mid-transaction aborts it immediately: no memory write, and `rdata`/`error` are cleared.

## Test plan
- **Reset:** hold PRESETn low for 3 cycles. All outputs read 0 and PREADY=1. After release, reading every address returns 00000000.
- **Write sequence:**
  - Write addr 0, DEADBEEF, strb 1111.
  - Write addr 4, ABCDABCD, strb 0101.
  - Write addr 8, 12345678, strb 1010.
  - Each write shows exactly one SETUP cycle then one ACCESS cycle, with PWRITE=1 and PSTRB equal to `strb`.
- **Readback:**
  - Read 0 with prot 111, pnse 1: rdata=DEADBEEF, error=0, PPROT=111, PNSE=1.
  - Read 4 with prot 101: rdata=00CD00CD.
  - Read 8 with prot 010: rdata=12005600. PSTRB=0000 during reads.
- **Error:**
  - Write to addr 40 (DEPTH=16, out of range): error=1, and no memory word changes.
  - Read from addr 2 (unaligned): error=1, rdata=0.
  - A subsequent valid read clears error to 0.
- **Back-to-back:** hold `transfer` high across completion. SETUP/ACCESS pairs repeat with no IDLE gap, and both results are correct.
- **Reset mid-ACCESS:** assert PRESETn low during ACCESS of a write to addr 0. The FSM goes to IDLE at once, the memory is unchanged (all 0), and `rdata`/`error` are 0.

Source files
------------

// File: rtl/apb_top.sv
// rtl/apb_top.sv - APB requester plus zero-wait-state byte-strobed register completer
//
// A local command port issues single-cycle `transfer` requests. The requester
// turns each request into an APB SETUP/ACCESS transaction on an internal bus,
// and that bus is exposed on output ports so it can be observed. An internal
// completer backs the bus with DEPTH 32-bit words of byte-strobed memory.
//
// Parameters
//   DEPTH     number of 32-bit words in the completer memory
// Command side
//   PCLK      clock, rising edge
//   PRESETn   asynchronous active-low reset
//   transfer  request strobe, sampled in IDLE or on an ACCESS completion edge
//   write_en  1 = write, 0 = read
//   waddr     byte address for reads and writes
//   wdata     write data
//   strb      write byte strobes, bit n enables lane [8n+7:8n]
//   prot      protection attributes, driven to PPROT
//   pnse      non-secure extension attribute, driven to PNSE
//   error     registered PSLVERR of the last completed transfer
//   rdata     registered read data of the last completed read
// Observed APB bus
//   PSELx PENABLE PADDR PWRITE PWDATA PSTRB PPROT PNSE   requester outputs
//   PRDATA PREADY PSLVERR                                completer outputs

module apb_top #(
   parameter int DEPTH = 16
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        transfer,
   input  logic        write_en,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   input  logic [3:0]  strb,
   input  logic [2:0]  prot,
   input  logic        pnse,
   output logic        error,
   output logic [31:0] rdata,
   output logic        PSELx,
   output logic        PENABLE,
   output logic [31:0] PADDR,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSTRB,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [2:0]  PPROT,
   output logic        PNSE
);

   localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             start;
   logic             complete;
   logic             addr_ok;
   logic [IDX_W-1:0] word_idx;
   logic [31:0]      mem [DEPTH];

   // ---------------- requester FSM ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // start marks every edge that enters SETUP, so request capture and the
   // FSM cannot disagree about which `transfer` samples are honoured.
   always_comb begin
      state_next = state;
      PSELx      = 1'b0;
      PENABLE    = 1'b0;
      start      = 1'b0;
      complete   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (transfer) begin
               state_next = ST_SETUP;
               start      = 1'b1;
            end
         end
         ST_SETUP: begin
            PSELx      = 1'b1;
            state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            PSELx   = 1'b1;
            PENABLE = 1'b1;
            if (PREADY) begin
               complete = 1'b1;
               if (transfer) begin
                  state_next = ST_SETUP;
                  start      = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Request capture: held stable from SETUP through ACCESS.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         PSTRB  <= '0;
         PPROT  <= '0;
         PNSE   <= 1'b0;
      end else if (start) begin
         PADDR  <= waddr;
         PWRITE <= write_en;
         PWDATA <= wdata;
         PSTRB  <= write_en ? strb : 4'b0000;
         PPROT  <= prot;
         PNSE   <= pnse;
      end
   end

   // ---------------- completer ----------------
   assign PREADY   = 1'b1;
   assign addr_ok  = (PADDR < ADDR_LIMIT) && (PADDR[1:0] == 2'b00);
   // Only meaningful when addr_ok; the range check guarantees the dropped
   // upper address bits are zero, so an invalid address never aliases a word.
   assign word_idx = PADDR[IDX_W+1:2];
   assign PSLVERR  = PSELx & PENABLE & ~addr_ok;

   always_comb begin
      PRDATA = '0;
      if (PSELx && !PWRITE && addr_ok) begin
         PRDATA = mem[word_idx];
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (complete && PWRITE && !PSLVERR) begin
         for (int b = 0; b < 4; b++) begin
            if (PSTRB[b]) begin
               mem[word_idx][8*b +: 8] <= PWDATA[8*b +: 8];
            end
         end
      end
   end

   // ---------------- completion results ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         error <= 1'b0;
         rdata <= '0;
      end else if (complete) begin
         error <= PSLVERR;
         if (!PWRITE) begin
            rdata <= PRDATA;
         end
      end
   end

endmodule

// File: tb/tb_apb_top.sv
// tb/tb_apb_top.sv - directed self-checking bench for apb_top

module tb_apb_top;

   logic        PCLK;
   logic        PRESETn;
   logic        transfer;
   logic        write_en;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [3:0]  strb;
   logic [2:0]  prot;
   logic        pnse;
   logic        error;
   logic [31:0] rdata;
   logic        PSELx;
   logic        PENABLE;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [2:0]  PPROT;
   logic        PNSE;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_rd;

   apb_top #(.DEPTH(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .write_en(write_en),
      .waddr(waddr), .wdata(wdata), .strb(strb), .prot(prot), .pnse(pnse),
      .error(error), .rdata(rdata), .PSELx(PSELx), .PENABLE(PENABLE),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PPROT(PPROT),
      .PNSE(PNSE)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, input logic ns);
      transfer = 1'b1;
      write_en = we;
      waddr    = a;
      wdata    = d;
      strb     = s;
      prot     = p;
      pnse     = ns;
   endtask

   // One isolated transfer, checked phase by phase. Called with inputs
   // changing just after a falling edge.
   task automatic xfer(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                       input logic ns, input logic exp_err, input logic [31:0] exp_rd);
      drive(we, a, d, s, p, ns);
      @(posedge PCLK); #1;
      check({tag, " setup psel"},    {31'd0, PSELx},   32'd1);
      check({tag, " setup penable"}, {31'd0, PENABLE}, 32'd0);
      check({tag, " setup paddr"},   PADDR, a);
      check({tag, " setup pwrite"},  {31'd0, PWRITE},  {31'd0, we});
      check({tag, " setup pstrb"},   {28'd0, PSTRB},   {28'd0, (we ? s : 4'b0000)});
      check({tag, " setup pprot"},   {29'd0, PPROT},   {29'd0, p});
      check({tag, " setup pnse"},    {31'd0, PNSE},    {31'd0, ns});
      @(negedge PCLK);
      transfer = 1'b0;
      @(posedge PCLK); #1;
      check({tag, " access psel"},    {31'd0, PSELx},   32'd1);
      check({tag, " access penable"}, {31'd0, PENABLE}, 32'd1);
      check({tag, " access pslverr"}, {31'd0, PSLVERR}, {31'd0, exp_err});
      if (!we) check({tag, " access prdata"}, PRDATA, exp_rd);
      @(posedge PCLK); #1;
      check({tag, " idle psel"}, {31'd0, PSELx}, 32'd0);
      check({tag, " error"},     {31'd0, error}, {31'd0, exp_err});
      check({tag, " rdata"},     rdata, exp_rd);
      @(negedge PCLK);
   endtask

   initial begin
      PRESETn  = 1'b0;
      transfer = 1'b0;
      write_en = 1'b0;
      waddr    = '0;
      wdata    = '0;
      strb     = '0;
      prot     = '0;
      pnse     = 1'b0;
      last_rd  = '0;

      // Reset held for three cycles
      repeat (3) @(negedge PCLK);
      check("rst psel",    {31'd0, PSELx},   32'd0);
      check("rst penable", {31'd0, PENABLE}, 32'd0);
      check("rst paddr",   PADDR,            32'd0);
      check("rst pwrite",  {31'd0, PWRITE},  32'd0);
      check("rst pwdata",  PWDATA,           32'd0);
      check("rst pstrb",   {28'd0, PSTRB},   32'd0);
      check("rst pprot",   {29'd0, PPROT},   32'd0);
      check("rst pnse",    {31'd0, PNSE},    32'd0);
      check("rst prdata",  PRDATA,           32'd0);
      check("rst pslverr", {31'd0, PSLVERR}, 32'd0);
      check("rst error",   {31'd0, error},   32'd0);
      check("rst rdata",   rdata,            32'd0);
      check("rst pready",  {31'd0, PREADY},  32'd1);
      PRESETn = 1'b1;
      @(negedge PCLK);

      for (int i = 0; i < 16; i++) begin
         xfer($sformatf("clr rd%0d", i), 1'b0, 32'(i * 4), 32'd0, 4'hf, 3'd0, 1'b0, 1'b0, 32'd0);
      end

      // Writes
      xfer("wr0", 1'b1, 32'h0, 32'hDEADBEEF, 4'b1111, 3'b000, 1'b0, 1'b0, 32'd0);
      xfer("wr4", 1'b1, 32'h4, 32'hABCDABCD, 4'b0101, 3'b000, 1'b0, 1'b0, 32'd0);
      xfer("wr8", 1'b1, 32'h8, 32'h12345678, 4'b1010, 3'b000, 1'b0, 1'b0, 32'd0);

      // Readback with assorted protection attributes
      xfer("rd0", 1'b0, 32'h0, 32'h0, 4'b1111, 3'b111, 1'b1, 1'b0, 32'hDEADBEEF);
      xfer("rd4", 1'b0, 32'h4, 32'h0, 4'b1111, 3'b101, 1'b0, 1'b0, 32'h00CD00CD);
      xfer("rd8", 1'b0, 32'h8, 32'h0, 4'b1111, 3'b010, 1'b0, 1'b0, 32'h12005600);

      // Errors: out-of-range write leaves rdata alone, unaligned read zeroes it
      xfer("wr oor", 1'b1, 32'h40, 32'hFFFFFFFF, 4'b1111, 3'b000, 1'b0, 1'b1, 32'h12005600);
      xfer("rd unal", 1'b0, 32'h2, 32'h0, 4'b0000, 3'b000, 1'b0, 1'b1, 32'h0);
      xfer("rd0 post", 1'b0, 32'h0, 32'h0, 4'b0000, 3'b000, 1'b0, 1'b0, 32'hDEADBEEF);
      xfer("rd4 post", 1'b0, 32'h4, 32'h0, 4'b0000, 3'b000, 1'b0, 1'b0, 32'h00CD00CD);
      xfer("rd3c post", 1'b0, 32'h3C, 32'h0, 4'b0000, 3'b000, 1'b0, 1'b0, 32'h0);

      // Back-to-back: read 0 then read 8 with no IDLE between
      drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b001, 1'b0);
      @(posedge PCLK); #1;
      check("b2b setup1 psel", {31'd0, PSELx}, 32'd1);
      @(negedge PCLK);
      drive(1'b0, 32'h8, 32'h0, 4'h0, 3'b001, 1'b0);
      @(posedge PCLK); #1;
      check("b2b access1 penable", {31'd0, PENABLE}, 32'd1);
      @(posedge PCLK); #1;
      check("b2b setup2 psel",    {31'd0, PSELx},   32'd1);
      check("b2b setup2 penable", {31'd0, PENABLE}, 32'd0);
      check("b2b setup2 paddr",   PADDR,            32'h8);
      check("b2b rdata1",         rdata,            32'hDEADBEEF);
      @(negedge PCLK);
      transfer = 1'b0;
      @(posedge PCLK); #1;
      check("b2b access2 penable", {31'd0, PENABLE}, 32'd1);
      @(posedge PCLK); #1;
      check("b2b idle psel", {31'd0, PSELx}, 32'd0);
      check("b2b rdata2",    rdata,          32'h12005600);
      check("b2b error2",    {31'd0, error}, 32'd0);
      @(negedge PCLK);

      // Reset during ACCESS of a write to address 0
      drive(1'b1, 32'h0, 32'h11111111, 4'hf, 3'b000, 1'b0);
      @(posedge PCLK);
      @(negedge PCLK);
      transfer = 1'b0;
      @(posedge PCLK); #1;
      check("mid access penable", {31'd0, PENABLE}, 32'd1);
      #2;
      PRESETn = 1'b0;
      #1;
      check("mid rst psel",    {31'd0, PSELx},   32'd0);
      check("mid rst penable", {31'd0, PENABLE}, 32'd0);
      check("mid rst rdata",   rdata,            32'd0);
      check("mid rst error",   {31'd0, error},   32'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      xfer("mid rd0", 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b0, 1'b0, 32'h0);
      xfer("mid rd4", 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 1'b0, 1'b0, 32'h0);
      xfer("mid rd8", 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, 1'b0, 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
